aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
Round-key responder for the AES encryption core. It sits on the core's key request interface (key_req/key_sel/key_vld) and serves the other end of that handshake. It latches a 128-bit cipher key, expands it into 11 round keys (FIPS-197 AES-128 schedule) at one round key per cycle, and stores them. It then answers each round-key request with the selected key one cycle later.

Parameters:
NO_ROWS, 4, state/key matrix rows (fixed 4 for AES-128)
NO_COLS, 4, state/key matrix columns (one column = one 32-bit key word)
NO_ROUNDS, 10, number of expanded rounds; slots 0..NO_ROUNDS stored

Ports:
aes_clk  in  1  clock
resetn  in  1  asynchronous active-low reset
key_load_i  in  1  pulse: latch cipher_key_i and start expansion
cipher_key_i  in  [7:0] [NO_ROWS-1:0][NO_COLS-1:0]  cipher key matrix; word c = bytes [0..3][c], [0][c] is MSB
key_req_i  in  1  round-key request (level, from core key_req_o)
key_sel_i  in  4  round-key index 0..10 (from core key_sel_o)
key_vld_o  out  1  round_key_o valid, 1-cycle pulse per served request
round_key_o  out  [7:0] [NO_ROWS-1:0][NO_COLS-1:0]  selected round key matrix
key_err_o  out  1  pulses with key_vld_o when key_sel_i > NO_ROUNDS
sched_rdy_o  out  1  full schedule valid

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is aes_clk. All outputs go to 0, round_key_o goes to all-zero, the key store is cleared, and the FSM enters IDLE.
- FSM states:
  - IDLE: no valid schedule.
  - EXPAND: round counter rc runs 1..NO_ROUNDS.
  - READY: sched_rdy_o=1.
- key_load_i sampled high in any state:
  - slot0 <= cipher_key_i.
  - rc <= 1.
  - State goes to EXPAND.
  - sched_rdy_o <= 0 in the following cycle.
  - key_load_i during EXPAND restarts expansion from the new key.
- EXPAND, each cycle: slot[rc] <= f(slot[rc-1], rc), then rc++.
  - When rc == NO_ROUNDS has been written, state goes to READY.
  - Timing: load sampled at edge N gives sched_rdy_o=1 after edge N+10.
- Round function f, with w0..w3 as the previous key's columns:
  - t = SubWord(RotWord(w3)) ^ {rcon[rc],00,00,00}.
  - RotWord moves byte [1] to [0], [2] to [1], [3] to [2], [0] to [3].
  - SubWord applies the AES S-box to each byte.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - All arithmetic is bytewise XOR; there are no carries.
- Request handshake:
  - Requests are served only in READY, and key_req_i and key_sel_i are sampled together.
  - key_req_i=1 sampled at edge N in READY gives key_vld_o=1 and round_key_o=slot[key_sel_i] after edge N. Latency is 1 cycle.
  - key_vld_o is a 1-cycle pulse. If key_req_i stays high, a new pulse is produced every cycle, so the requester drops key_req_i on seeing key_vld_o.
  - round_key_o holds its last value while key_vld_o=0.
- Requests in IDLE or EXPAND get no response. key_vld_o stays 0 and the request stays pending on the level of key_req_i, to be served on the first READY cycle.
- key_sel_i > NO_ROUNDS: key_vld_o=1, key_err_o=1, round_key_o=all-zero.
- key_load_i and key_req_i sampled high on the same edge:
  - The load wins.
  - No key_vld_o is produced.
  - The request waits for the new schedule.
- resetn asserted mid-expansion: immediate return to IDLE with the store cleared. A later request gets no response until a new key_load_i completes.

Decomposition:
- Shared package aes_pkg holds:
  - the AES S-box constant table, 256 x 8 bits, shared with the encryption core's sbox;
  - the rcon constant array;
  - a matrix typedef aes_mat_t (byte [NO_ROWS][NO_COLS]);
  - state enum key_sched_state_e {IDLE, EXPAND, READY};
  - function sub_word.
- One sub-module is natural: aes_key_round, a combinational f(prev_key, rc) producing next_key. It is reused by a future on-the-fly decryption key path.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: load, then wait. sched_rdy_o must rise exactly 10 cycles after the load edge. Request sel=1: key_vld_o one cycle later with a0fafe17_88542cb1_23a33939_2a6c7605 (column 0 = a0,fa,fe,17).
2. Same key, request sel=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6. Request sel=0 -> the cipher key unchanged.
3. Request sel=3 held high from the load cycle. No key_vld_o before READY; the first key_vld_o arrives on the cycle after sched_rdy_o rises, with 3d80477d_4716fe3e_1e237e44_6d7a883b.
4. Request sel=12 in READY -> key_vld_o=1, key_err_o=1, round_key_o=0.
5. Load a second key (all-zero) at rc=5 of the first expansion. Expansion restarts: ready 10 cycles after the second load. Request sel=1 -> 62636363_62636363_62636363_62636363.
6. Assert resetn low mid-expansion, then release. All outputs are 0 and sched_rdy_o=0. A request with no reload gets no key_vld_o for 20 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box, round constants, key matrix and
// key-schedule state encoding.
package aes_pkg;

    localparam int unsigned NO_ROWS   = 4;
    localparam int unsigned NO_COLS   = 4;
    localparam int unsigned NO_ROUNDS = 10;
    localparam int unsigned RC_W      = 4;

    // m[row][col]; one column is one 32-bit key word with row 0 as its MSB
    typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] aes_mat_t;
    typedef logic [NO_ROWS-1:0][7:0]              aes_word_t;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} key_sched_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by round counter; entries beyond the last round are unused padding
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic aes_word_t sub_word(input aes_word_t w);
        aes_word_t res;
        for (int r = 0; r < NO_ROWS; r++) begin
            res[r] = SBOX[w[r]];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: next round key from previous key and round index.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] prev_key_i,
    input  logic [RC_W-1:0]                      rc_i,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] next_key_o
);

    aes_word_t rot_w;
    aes_word_t acc_w;

    always_comb begin
        rot_w[0] = prev_key_i[1][NO_COLS-1];
        rot_w[1] = prev_key_i[2][NO_COLS-1];
        rot_w[2] = prev_key_i[3][NO_COLS-1];
        rot_w[3] = prev_key_i[0][NO_COLS-1];
        acc_w    = sub_word(rot_w);
        acc_w[0] = acc_w[0] ^ RCON[rc_i];
        // Each new column chains off the one just produced
        for (int c = 0; c < NO_COLS; c++) begin
            for (int r = 0; r < NO_ROWS; r++) begin
                acc_w[r]         = acc_w[r] ^ prev_key_i[r][c];
                next_key_o[r][c] = acc_w[r];
            end
        end
    end

endmodule

// File: rtl/aes_key_sched.sv
// Round-key responder: expands a loaded AES-128 key one round per cycle and
// serves round-key requests from the encryption core with 1-cycle latency.
module aes_key_sched
    import aes_pkg::*;
(
    input  logic                                 aes_clk,
    input  logic                                 resetn,
    input  logic                                 key_load_i,
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_key_i,
    input  logic                                 key_req_i,
    input  logic [3:0]                           key_sel_i,
    output logic                                 key_vld_o,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] round_key_o,
    output logic                                 key_err_o,
    output logic                                 sched_rdy_o
);

    localparam int unsigned      NO_SLOTS = NO_ROUNDS + 1;
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(NO_ROUNDS);

    key_sched_state_e state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    aes_mat_t         key_store_q [NO_SLOTS];
    aes_mat_t         key_store_d [NO_SLOTS];
    aes_mat_t         prev_key_q, prev_key_d;
    aes_mat_t         round_key_q, round_key_d;
    aes_mat_t         next_key;
    logic             key_vld_q, key_vld_d;
    logic             key_err_q, key_err_d;
    logic             sched_rdy_q, sched_rdy_d;

    aes_key_round u_key_round (
        .prev_key_i (prev_key_q),
        .rc_i       (rc_q),
        .next_key_o (next_key)
    );

    // Next state, key store update and request response
    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        key_store_d = key_store_q;
        prev_key_d  = prev_key_q;
        round_key_d = round_key_q;
        key_vld_d   = 1'b0;
        key_err_d   = 1'b0;

        if (key_load_i) begin
            key_store_d[0] = cipher_key_i;
            prev_key_d     = cipher_key_i;
            rc_d           = RC_W'(1);
            state_d        = EXPAND;
        end else begin
            case (state_q)
                EXPAND: begin
                    key_store_d[rc_q] = next_key;
                    prev_key_d        = next_key;
                    if (rc_q == LAST_RC) begin
                        rc_d    = '0;
                        state_d = READY;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                READY: begin
                    if (key_req_i) begin
                        key_vld_d = 1'b1;
                        if (key_sel_i > LAST_RC) begin
                            key_err_d   = 1'b1;
                            round_key_d = '0;
                        end else begin
                            round_key_d = key_store_q[key_sel_i];
                        end
                    end
                end
                default: ;
            endcase
        end

        sched_rdy_d = (state_d == READY);
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rc_q        <= '0;
            prev_key_q  <= '0;
            round_key_q <= '0;
            key_vld_q   <= 1'b0;
            key_err_q   <= 1'b0;
            sched_rdy_q <= 1'b0;
            for (int i = 0; i < NO_SLOTS; i++) begin
                key_store_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            prev_key_q  <= prev_key_d;
            round_key_q <= round_key_d;
            key_vld_q   <= key_vld_d;
            key_err_q   <= key_err_d;
            sched_rdy_q <= sched_rdy_d;
            for (int i = 0; i < NO_SLOTS; i++) begin
                key_store_q[i] <= key_store_d[i];
            end
        end
    end

    assign key_vld_o   = key_vld_q;
    assign key_err_o   = key_err_q;
    assign round_key_o = round_key_q;
    assign sched_rdy_o = sched_rdy_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors, protocol corner
// cases and random keys against a word-level key-expansion model.
module tb_aes_key_sched;

    logic                  aes_clk = 1'b0;
    logic                  resetn;
    logic                  key_load_i;
    logic [3:0][3:0][7:0]  cipher_key_i;
    logic                  key_req_i;
    logic [3:0]            key_sel_i;
    logic                  key_vld_o;
    logic [3:0][3:0][7:0]  round_key_o;
    logic                  key_err_o;
    logic                  sched_rdy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] ref_rk [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 aes_clk = ~aes_clk;

    aes_key_sched dut (
        .aes_clk      (aes_clk),
        .resetn       (resetn),
        .key_load_i   (key_load_i),
        .cipher_key_i (cipher_key_i),
        .key_req_i    (key_req_i),
        .key_sel_i    (key_sel_i),
        .key_vld_o    (key_vld_o),
        .round_key_o  (round_key_o),
        .key_err_o    (key_err_o),
        .sched_rdy_o  (sched_rdy_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            if (i != 0) begin
                inv = 8'(i);
                for (int k = 0; k < 253; k++) inv = gmul(inv, 8'(i));
            end
            r = inv; s = inv;
            repeat (4) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_m[i] = s ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) ref_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] mat_to_hex(input logic [3:0][3:0][7:0] m);
        logic [127:0] h;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                h[127-8*(4*c+r) -: 8] = m[r][c];
        return h;
    endfunction

    function automatic logic [3:0][3:0][7:0] hex_to_mat(input logic [127:0] h);
        logic [3:0][3:0][7:0] m;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = h[127-8*(4*c+r) -: 8];
        return m;
    endfunction

    task automatic tick();
        @(posedge aes_clk);
        #1;
    endtask

    task automatic do_load(input logic [127:0] key);
        cipher_key_i = hex_to_mat(key);
        key_load_i   = 1'b1;
        expand_key(key);
        tick();
        key_load_i   = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output int vlds);
        cyc = 0; vlds = 0;
        while (!sched_rdy_o && cyc < 40) begin
            tick();
            cyc++;
            if (key_vld_o) vlds++;
        end
    endtask

    task automatic request(input logic [3:0] sel);
        key_req_i = 1'b1;
        key_sel_i = sel;
        tick();
        key_req_i = 1'b0;
        check($sformatf("req%0d_vld", sel), 128'(key_vld_o), 128'd1);
        check($sformatf("req%0d_err", sel), 128'(key_err_o), (sel > 4'd10) ? 128'd1 : 128'd0);
        check($sformatf("req%0d_key", sel), mat_to_hex(round_key_o), (sel > 4'd10) ? 128'd0 : ref_rk[sel]);
    endtask

    initial begin
        int cyc, vlds;
        logic [127:0] k1, k2, held;

        resetn = 1'b0; key_load_i = 1'b0; key_req_i = 1'b0; key_sel_i = '0; cipher_key_i = '0;
        build_sbox();
        tick(); tick();
        check("rst_vld", 128'(key_vld_o), 128'd0);
        check("rst_err", 128'(key_err_o), 128'd0);
        check("rst_rdy", 128'(sched_rdy_o), 128'd0);
        check("rst_key", mat_to_hex(round_key_o), 128'd0);
        resetn = 1'b1;
        tick();

        // FIPS-197 key: ready latency, rounds 1, 10 and 0, output hold
        do_load(FIPS_KEY);
        wait_ready(cyc, vlds);
        check("t1_rdy_lat", 128'(cyc), 128'd10);
        request(4'd1);
        check("t1_sel1_fips", mat_to_hex(round_key_o), 128'ha0fafe1788542cb123a339392a6c7605);
        held = mat_to_hex(round_key_o);
        tick();
        check("t1_vld_pulse", 128'(key_vld_o), 128'd0);
        check("t1_key_hold", mat_to_hex(round_key_o), held);
        request(4'd10);
        check("t2_sel10_fips", mat_to_hex(round_key_o), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        request(4'd0);
        check("t2_sel0_fips", mat_to_hex(round_key_o), FIPS_KEY);

        // Request held from the load edge: load wins, served on first READY cycle
        key_req_i = 1'b1; key_sel_i = 4'd3;
        do_load(FIPS_KEY);
        wait_ready(cyc, vlds);
        check("t3_rdy_lat", 128'(cyc), 128'd10);
        check("t3_early_vld", 128'(vlds), 128'd0);
        tick();
        check("t3_vld", 128'(key_vld_o), 128'd1);
        check("t3_sel3_fips", mat_to_hex(round_key_o), 128'h3d80477d4716fe3e1e237e446d7a883b);
        key_req_i = 1'b0;
        tick();
        check("t3_vld_drop", 128'(key_vld_o), 128'd0);

        request(4'd12);

        // Reload mid-expansion restarts from the new key
        do_load(FIPS_KEY);
        repeat (4) tick();
        do_load(128'd0);
        wait_ready(cyc, vlds);
        check("t5_rdy_lat", 128'(cyc), 128'd10);
        request(4'd1);
        check("t5_sel1_zero", mat_to_hex(round_key_o), 128'h62636363626363636263636362636363);

        // Asynchronous reset mid-expansion clears everything
        do_load(FIPS_KEY);
        repeat (3) tick();
        resetn = 1'b0;
        #2;
        check("t6_rst_vld", 128'(key_vld_o), 128'd0);
        check("t6_rst_err", 128'(key_err_o), 128'd0);
        check("t6_rst_rdy", 128'(sched_rdy_o), 128'd0);
        check("t6_rst_key", mat_to_hex(round_key_o), 128'd0);
        tick();
        resetn = 1'b1;
        key_req_i = 1'b1; key_sel_i = 4'd1;
        vlds = 0;
        repeat (20) begin
            tick();
            if (key_vld_o) vlds++;
        end
        key_req_i = 1'b0;
        check("t6_no_vld", 128'(vlds), 128'd0);
        check("t6_no_rdy", 128'(sched_rdy_o), 128'd0);

        // Random keys, optional mid-expansion reload, random selections
        for (int it = 0; it < 6; it++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            do_load(k1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 9)) tick();
                k2 = {$urandom, $urandom, $urandom, $urandom};
                do_load(k2);
            end
            wait_ready(cyc, vlds);
            check($sformatf("rnd%0d_rdy_lat", it), 128'(cyc), 128'd10);
            for (int j = 0; j < 6; j++) begin
                request(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 1) begin
                    held = mat_to_hex(round_key_o);
                    tick();
                    check($sformatf("rnd%0d_hold", it), mat_to_hex(round_key_o), held);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
